mem_arbiter: RTL

Sequencing controller for the single shared, multi-cycle memory port between instruction fetch and the data-memory access carried in the EX/MEM pipeline register. It arbitrates between the two requesters, drives a one-shot memory handshake, and returns read data with a one-cycle valid pulse. It also generates the stall signals that freeze the PC/IF-ID and ID-EX/EX-MEM registers while an access is outstanding, and flags protocol errors and memory timeouts.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the single shared multi-cycle memory port used by
// instruction fetch and the EX/MEM data access; also drives the pipeline stalls.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [15:0] if_addr_i,
    input  logic        dm_rd_i,
    input  logic        dm_wr_i,
    input  logic [15:0] dm_addr_i,
    input  logic [15:0] dm_wdata_i,
    input  logic [15:0] mem_rdata_i,
    input  logic        mem_done_i,
    output logic        mem_en_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    output logic [15:0] if_rdata_o,
    output logic        if_valid_o,
    output logic [15:0] dm_rdata_o,
    output logic        dm_valid_o,
    output logic        stall_fe_o,
    output logic        stall_pipe_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic [4:0] TimeoutCnt = 5'(TIMEOUT);

    state_e      state_q;
    logic        owner_q;
    logic        lastOwner_q;
    logic        armed_q;
    logic [4:0]  cnt_q;
    logic        memEn_q;
    logic        memWr_q;
    logic [15:0] memAddr_q;
    logic [15:0] memWdata_q;
    logic [15:0] ifRdata_q;
    logic [15:0] dmRdata_q;
    logic        ifValid_q;
    logic        dmValid_q;
    logic        err_q;

    logic        dmReq_d;
    logic        anyReq_d;
    logic        grantData_d;
    logic        conflict_d;
    logic        strayDone_d;
    logic        timeout_d;
    logic [4:0]  cnt_d;
    logic [15:0] respWord_d;

    // On a tie the side that did not complete last wins. A completion pulse
    // before the first grant since reset is the tail of an abandoned access,
    // so it is only treated as a protocol error once armed_q is set.
    always_comb begin
        dmReq_d     = dm_rd_i | dm_wr_i;
        anyReq_d    = dmReq_d | if_req_i;
        grantData_d = dmReq_d & (~if_req_i | ~lastOwner_q);
        conflict_d  = dm_rd_i & dm_wr_i;
        strayDone_d = mem_done_i & armed_q & (state_q != WAIT);
        cnt_d       = cnt_q + 5'd1;
        timeout_d   = (cnt_d >= TimeoutCnt);
        respWord_d  = mem_done_i ? mem_rdata_i : 16'h0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastOwner_q <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= 5'd0;
            memEn_q     <= 1'b0;
            memWr_q     <= 1'b0;
            memAddr_q   <= 16'h0000;
            memWdata_q  <= 16'h0000;
            ifRdata_q   <= 16'h0000;
            dmRdata_q   <= 16'h0000;
            ifValid_q   <= 1'b0;
            dmValid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            memEn_q   <= 1'b0;
            ifValid_q <= 1'b0;
            dmValid_q <= 1'b0;
            if (strayDone_d) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (anyReq_d) begin
                        state_q    <= ISSUE;
                        owner_q    <= grantData_d;
                        armed_q    <= 1'b1;
                        memEn_q    <= 1'b1;
                        memWr_q    <= grantData_d & dm_wr_i;
                        memAddr_q  <= grantData_d ? dm_addr_i : if_addr_i;
                        memWdata_q <= grantData_d ? dm_wdata_i : 16'h0000;
                        if (grantData_d & conflict_d) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q   <= 5'd0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    // A completion arriving on the timeout cycle still counts as good.
                    if (mem_done_i || timeout_d) begin
                        state_q    <= RESP;
                        memWr_q    <= 1'b0;
                        memAddr_q  <= 16'h0000;
                        memWdata_q <= 16'h0000;
                        if (mem_done_i) begin
                            lastOwner_q <= owner_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (owner_q) begin
                            dmValid_q <= 1'b1;
                            dmRdata_q <= respWord_d;
                        end else begin
                            ifValid_q <= 1'b1;
                            ifRdata_q <= respWord_d;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en_o     = memEn_q;
    assign mem_wr_o     = memWr_q;
    assign mem_addr_o   = memAddr_q;
    assign mem_wdata_o  = memWdata_q;
    assign if_rdata_o   = ifRdata_q;
    assign if_valid_o   = ifValid_q;
    assign dm_rdata_o   = dmRdata_q;
    assign dm_valid_o   = dmValid_q;
    assign err_o        = err_q;
    assign stall_fe_o   = if_req_i & ~ifValid_q;
    assign stall_pipe_o = dmReq_d & ~dmValid_q;

endmodule
